// File: rtl/inst_rom_arb_pkg.sv
// rtl/inst_rom_arb_pkg.sv - shared bus widths, constants and FSM encoding for the ROM arbiter
package inst_rom_arb_pkg;

  localparam int          InstAddrBus   = 32;
  localparam int          InstBus       = 32;
  localparam logic [31:0] ZeroWord      = 32'h0000_0000;
  localparam logic        ChipEnable    = 1'b1;
  localparam logic        ChipDisable   = 1'b0;
  localparam int          RomWaitCycles = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic misaligned(input logic [InstAddrBus-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_rom_arb_rr_arb2.sv
// rtl/inst_rom_arb_rr_arb2.sv - two-requester round-robin priority, one-hot grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // last = 1 means requester 1 won the previous arbitration
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/inst_rom_arb.sv
// rtl/inst_rom_arb.sv - arbitrates fetch (m0) and debug/loader (m1) reads onto one instruction ROM
module inst_rom_arb
  import inst_rom_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = RomWaitCycles
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic [InstAddrBus-1:0] m0_addr,
  output logic                   m0_gnt,
  output logic                   m0_rvalid,
  output logic [InstBus-1:0]     m0_rdata,
  output logic                   m0_err,
  input  logic                   m1_req,
  input  logic [InstAddrBus-1:0] m1_addr,
  output logic                   m1_gnt,
  output logic                   m1_rvalid,
  output logic [InstBus-1:0]     m1_rdata,
  output logic                   m1_err,
  output logic                   rom_ce,
  output logic [InstAddrBus-1:0] rom_addr,
  input  logic [InstBus-1:0]     rom_inst
);

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_t                 state;
  logic [3:0]             cnt;
  logic                   last;
  logic                   owner;
  logic                   err_q;
  logic [InstAddrBus-1:0] addr_q;
  logic [InstBus-1:0]     rdata0;
  logic [InstBus-1:0]     rdata1;
  logic [1:0]             arb_gnt;
  logic [1:0]             gnt;
  logic [InstAddrBus-1:0] sel_addr;

  rr_arb2 u_rr_arb2 (
    .req  ({m1_req, m0_req}),
    .last (last),
    .gnt  (arb_gnt)
  );

  // Grants are only offered from IDLE and never while reset is held
  assign gnt      = (state == ST_IDLE && rst) ? arb_gnt : 2'b00;
  assign sel_addr = gnt[1] ? m1_addr : m0_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      last   <= 1'b1;
      owner  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= ZeroWord;
      rdata0 <= ZeroWord;
      rdata1 <= ZeroWord;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            owner  <= gnt[1];
            last   <= gnt[1];
            addr_q <= sel_addr;
            cnt    <= 4'd0;
            if (misaligned(sel_addr)) begin
              err_q <= 1'b1;
              if (gnt[1]) rdata1 <= ZeroWord;
              else        rdata0 <= ZeroWord;
              state <= ST_RESP;
            end else begin
              err_q <= 1'b0;
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == LastCnt) begin
            cnt <= 4'd0;
            if (owner) rdata1 <= rom_inst;
            else       rdata0 <= rom_inst;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = (state == ST_RESP) && !owner;
  assign m1_rvalid = (state == ST_RESP) && owner;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;
  assign m0_rdata  = rdata0;
  assign m1_rdata  = rdata1;
  assign rom_ce    = (state == ST_ACCESS) ? ChipEnable : ChipDisable;
  assign rom_addr  = (state == ST_ACCESS) ? addr_q : ZeroWord;

endmodule

// File: tb/tb_inst_rom_arb.sv
// tb/tb_inst_rom_arb.sv - directed bench for inst_rom_arb with one- and three-cycle ROM instances
module tb_inst_rom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;

  logic        m0_gnt_a, m0_rvalid_a, m0_err_a, m1_gnt_a, m1_rvalid_a, m1_err_a, rom_ce_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, rom_addr_a, rom_inst_a;
  logic        m0_gnt_b, m0_rvalid_b, m0_err_b, m1_gnt_b, m1_rvalid_b, m1_err_b, rom_ce_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, rom_addr_b, rom_inst_b;

  logic [31:0] rom [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_inst_a = rom[rom_addr_a[5:2]];
  assign rom_inst_b = rom[rom_addr_b[5:2]];

  inst_rom_arb #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a),
    .m0_rdata(m0_rdata_a), .m0_err(m0_err_a),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a),
    .m1_rdata(m1_rdata_a), .m1_err(m1_err_a),
    .rom_ce(rom_ce_a), .rom_addr(rom_addr_a), .rom_inst(rom_inst_a)
  );

  inst_rom_arb #(.WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b),
    .m0_rdata(m0_rdata_b), .m0_err(m0_err_b),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b),
    .m1_rdata(m1_rdata_b), .m1_err(m1_err_b),
    .rom_ce(rom_ce_b), .rom_addr(rom_addr_b), .rom_inst(rom_inst_b)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h8; m1_req = 1'b1; m1_addr = 32'h4;
    #1;
    checks++; if ({m1_gnt_a, m0_gnt_a, m1_gnt_b, m0_gnt_b} !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", {m1_gnt_a, m0_gnt_a, m1_gnt_b, m0_gnt_b}); end
    @(negedge clk); #1;
    checks++; if ({rom_ce_a, m0_rvalid_a, m1_rvalid_a, m0_err_a, m1_err_a} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {rom_ce_a, m0_rvalid_a, m1_rvalid_a, m0_err_a, m1_err_a}); end
    checks++; if ({rom_addr_a, m0_rdata_a, m1_rdata_a} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {rom_addr_a, m0_rdata_a, m1_rdata_a}); end
    checks++; if ({rom_ce_b, rom_addr_b, m0_rdata_b} !== 65'h0) begin errors++; $display("FAIL reset_b: got %h expected 0", {rom_ce_b, rom_addr_b, m0_rdata_b}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({m1_gnt_a, m0_gnt_a} !== 2'b01) begin errors++; $display("FAIL reset_first_tie: got %b expected 01", {m1_gnt_a, m0_gnt_a}); end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    m0_req = 1'b1; m0_addr = 32'h0000_0008;
    #1;
    checks++; if ({m1_gnt_a, m0_gnt_a} !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", {m1_gnt_a, m0_gnt_a}); end
    @(negedge clk);
    m0_req = 1'b0; m0_addr = '0;
    #1;
    checks++; if (rom_ce_a !== 1'b1 || rom_addr_a !== 32'h8) begin errors++; $display("FAIL single_access: got ce=%b addr=%h expected ce=1 addr=00000008", rom_ce_a, rom_addr_a); end
    checks++; if (m0_rvalid_a !== 1'b0) begin errors++; $display("FAIL single_early_rvalid: got %b expected 0", m0_rvalid_a); end
    @(negedge clk); #1;
    checks++; if (m0_rvalid_a !== 1'b1 || m0_rdata_a !== 32'h3401_1100 || m0_err_a !== 1'b0) begin errors++; $display("FAIL single_resp: got v=%b d=%h e=%b expected v=1 d=34011100 e=0", m0_rvalid_a, m0_rdata_a, m0_err_a); end
    checks++; if (m1_rvalid_a !== 1'b0 || rom_ce_a !== 1'b0) begin errors++; $display("FAIL single_resp_side: got m1v=%b ce=%b expected 0 0", m1_rvalid_a, rom_ce_a); end
    @(negedge clk); #1;
    checks++; if (m0_rvalid_a !== 1'b0 || m0_rdata_a !== 32'h3401_1100) begin errors++; $display("FAIL single_hold: got v=%b d=%h expected v=0 d=34011100", m0_rvalid_a, m0_rdata_a); end
  endtask

  task automatic test_tie();
    logic [31:0] exp_d;
    apply_reset();
    m0_req = 1'b1; m0_addr = 32'h0; m1_req = 1'b1; m1_addr = 32'h4;
    for (int c = 0; c < 12; c++) begin
      int phase;
      int own;
      phase = c % 3;
      own = (c / 3) % 2;
      #1;
      if (phase == 0) begin
        checks++; if ({m1_gnt_a, m0_gnt_a} !== (own == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_gnt%0d: got %b expected %b", c / 3, {m1_gnt_a, m0_gnt_a}, (own == 1 ? 2'b10 : 2'b01)); end
      end else begin
        checks++; if ({m1_gnt_a, m0_gnt_a} !== 2'b00) begin errors++; $display("FAIL tie_busy_gnt%0d: got %b expected 00", c, {m1_gnt_a, m0_gnt_a}); end
      end
      if (phase == 1) begin
        checks++; if (rom_addr_a !== (own == 1 ? 32'h4 : 32'h0)) begin errors++; $display("FAIL tie_addr%0d: got %h expected %h", c / 3, rom_addr_a, (own == 1 ? 32'h4 : 32'h0)); end
      end
      if (phase == 2) begin
        exp_d = (own == 1) ? 32'h2222_1111 : 32'h1111_0000;
        checks++; if ({m1_rvalid_a, m0_rvalid_a} !== (own == 1 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_rvalid%0d: got %b expected %b", c / 3, {m1_rvalid_a, m0_rvalid_a}, (own == 1 ? 2'b10 : 2'b01)); end
        checks++; if ((own == 1 ? m1_rdata_a : m0_rdata_a) !== exp_d) begin errors++; $display("FAIL tie_rdata%0d: got %h expected %h", c / 3, (own == 1 ? m1_rdata_a : m0_rdata_a), exp_d); end
      end
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_misaligned();
    apply_reset();
    m1_req = 1'b1; m1_addr = 32'h4;
    #1;
    checks++; if (m1_gnt_a !== 1'b1) begin errors++; $display("FAIL mis_pre_gnt: got %b expected 1", m1_gnt_a); end
    @(negedge clk);
    m1_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (m1_rdata_a !== 32'h2222_1111) begin errors++; $display("FAIL mis_pre_rdata: got %h expected 22221111", m1_rdata_a); end
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 32'h0000_0006;
    #1;
    checks++; if (m1_gnt_a !== 1'b1 || rom_ce_a !== 1'b0) begin errors++; $display("FAIL mis_gnt: got gnt=%b ce=%b expected gnt=1 ce=0", m1_gnt_a, rom_ce_a); end
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    checks++; if (m1_rvalid_a !== 1'b1 || m1_err_a !== 1'b1 || m1_rdata_a !== 32'h0) begin errors++; $display("FAIL mis_resp: got v=%b e=%b d=%h expected v=1 e=1 d=00000000", m1_rvalid_a, m1_err_a, m1_rdata_a); end
    checks++; if (rom_ce_a !== 1'b0 || m0_rvalid_a !== 1'b0 || m0_err_a !== 1'b0) begin errors++; $display("FAIL mis_side: got ce=%b m0v=%b m0e=%b expected 0 0 0", rom_ce_a, m0_rvalid_a, m0_err_a); end
    @(negedge clk); #1;
    checks++; if (m1_rvalid_a !== 1'b0 || m1_err_a !== 1'b0) begin errors++; $display("FAIL mis_after: got v=%b e=%b expected 0 0", m1_rvalid_a, m1_err_a); end
  endtask

  task automatic test_wait_states();
    int ce_cycles;
    apply_reset();
    m0_req = 1'b1; m0_addr = 32'hC; m1_req = 1'b1; m1_addr = 32'h4;
    #1;
    checks++; if ({m1_gnt_b, m0_gnt_b} !== 2'b01) begin errors++; $display("FAIL wait_gnt: got %b expected 01", {m1_gnt_b, m0_gnt_b}); end
    ce_cycles = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      m0_req = 1'b0;
      #1;
      if (rom_ce_b) ce_cycles++;
      checks++; if (m1_gnt_b !== 1'b0) begin errors++; $display("FAIL wait_busy_gnt%0d: got %b expected 0", c, m1_gnt_b); end
      checks++; if (m0_rvalid_b !== (c == 4)) begin errors++; $display("FAIL wait_rvalid%0d: got %b expected %b", c, m0_rvalid_b, (c == 4)); end
    end
    checks++; if (m0_rdata_b !== 32'h3C03_3333) begin errors++; $display("FAIL wait_rdata: got %h expected 3c033333", m0_rdata_b); end
    checks++; if (ce_cycles != 3) begin errors++; $display("FAIL wait_ce_cycles: got %0d expected 3", ce_cycles); end
    @(negedge clk); #1;
    checks++; if ({m1_gnt_b, m0_gnt_b} !== 2'b10) begin errors++; $display("FAIL wait_next_gnt: got %b expected 10", {m1_gnt_b, m0_gnt_b}); end
    m1_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    m0_req = 1'b1; m0_addr = 32'h8;
    #1;
    checks++; if (m0_gnt_a !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b expected 1", m0_gnt_a); end
    @(negedge clk); #1;
    checks++; if (rom_ce_a !== 1'b1) begin errors++; $display("FAIL rmid_ce: got %b expected 1", rom_ce_a); end
    rst = 1'b0;
    #1;
    checks++; if ({rom_ce_a, rom_addr_a, m0_gnt_a} !== 34'h0) begin errors++; $display("FAIL rmid_abort: got %h expected 0", {rom_ce_a, rom_addr_a, m0_gnt_a}); end
    @(negedge clk); #1;
    checks++; if ({m0_rvalid_a, m1_rvalid_a, m0_err_a, m0_rdata_a} !== 35'h0) begin errors++; $display("FAIL rmid_no_resp: got %h expected 0", {m0_rvalid_a, m1_rvalid_a, m0_err_a, m0_rdata_a}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({m1_gnt_a, m0_gnt_a} !== 2'b01) begin errors++; $display("FAIL rmid_regrant: got %b expected 01", {m1_gnt_a, m0_gnt_a}); end
    @(negedge clk);
    m0_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (m0_rvalid_a !== 1'b1 || m0_rdata_a !== 32'h3401_1100) begin errors++; $display("FAIL rmid_resp: got v=%b d=%h expected v=1 d=34011100", m0_rvalid_a, m0_rdata_a); end
  endtask

  task automatic test_withdrawn();
    apply_reset();
    m0_req = 1'b1; m0_addr = 32'h0;
    #1;
    checks++; if (m0_gnt_a !== 1'b1) begin errors++; $display("FAIL wd_gnt: got %b expected 1", m0_gnt_a); end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h4;
    #1;
    checks++; if (m1_gnt_a !== 1'b0) begin errors++; $display("FAIL wd_pulse_gnt: got %b expected 0", m1_gnt_a); end
    @(negedge clk);
    m1_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (m1_gnt_a !== 1'b0 || m1_rvalid_a !== 1'b0) begin errors++; $display("FAIL wd_m1_%0d: got gnt=%b rvalid=%b expected 0 0", c, m1_gnt_a, m1_rvalid_a); end
      if (c == 0) begin
        checks++; if (m0_rvalid_a !== 1'b1) begin errors++; $display("FAIL wd_m0_resp: got %b expected 1", m0_rvalid_a); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_high_addr();
    apply_reset();
    m1_req = 1'b1; m1_addr = 32'hFFFF_FFFC;
    #1;
    checks++; if (m1_gnt_a !== 1'b1) begin errors++; $display("FAIL high_gnt: got %b expected 1", m1_gnt_a); end
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    checks++; if (rom_addr_a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL high_addr: got %h expected fffffffc", rom_addr_a); end
    @(negedge clk); #1;
    checks++; if (m1_rvalid_a !== 1'b1 || m1_rdata_a !== 32'hF0F0_A5A5 || m1_err_a !== 1'b0) begin errors++; $display("FAIL high_resp: got v=%b d=%h e=%b expected v=1 d=f0f0a5a5 e=0", m1_rvalid_a, m1_rdata_a, m1_err_a); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0101_0101 * i;
    rom[0]  = 32'h1111_0000;
    rom[1]  = 32'h2222_1111;
    rom[2]  = 32'h3401_1100;
    rom[3]  = 32'h3C03_3333;
    rom[15] = 32'hF0F0_A5A5;
    test_reset();
    test_single();
    test_tie();
    test_misaligned();
    test_wait_states();
    test_reset_mid_access();
    test_withdrawn();
    test_high_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
